arcade_input_mapper: RTL
========================

// Module: arcade_input_mapper
// PURPOSE
//  Multi-player PS/2 + joystick input front end for arcade cores. Decodes ps2_key toggle events into held
//  key state and ORs it with per-player joystick buttons. Generates fixed-width, edge-triggered coin pulses
//  and registered start lines. Sits between hps_io and the game core.
// PARAMETERS
//  NUM_PLAYERS  2        players; each gets a joystick input and a button vector (1..4)
//  BTN_W        8        button bits per player: [0]R [1]L [2]D [3]U [4]F1 [5]F2 [7:6] spare (0)
//  NUM_COINS    2        coin slots (1..4)
//  COIN_PULSE   16'd2000 coin output high time in clk_sys cycles (>=1)
//  START_DELAY  16'd4000 coin-to-start gap in cycles (used only with COIN_ON_START_EN)
// PORTS
//  clk_sys    in   1                    system clock
//  reset      in   1                    synchronous, active-high
//  ps2_key    in   11                   [10] toggle, [9] pressed, [8] extended, [7:0] scan code
//  joystick   in   16*NUM_PLAYERS       player p at [16p+15:16p]; [4:0] as BTN bits, [5] F2, [6] start, [7] coin
//  buttons    out  BTN_W*NUM_PLAYERS    player p at [BTN_W*p+BTN_W-1:BTN_W*p], 1 = pressed
//  start      out  NUM_PLAYERS          start per player, 1 = pressed
//  coin       out  NUM_COINS            coin pulses, 1 = inserted
// BEHAVIOUR
//  - Reset: all key-state regs, buttons, start and coin = 0. Pulse counters = 0, FSM = IDLE.
//    toggle_q is loaded from ps2_key[10] during reset, so no event fires on the first cycle after reset.
//  - Event: ps2_key[10] != toggle_q. On an event, every keymap entry whose code matches sets its key bit to ps2_key[9].
//    Keymap entries carry an ext-care flag; arrow keys match ignoring [8], all other keys require [8]=0.
//    Non-matching codes have no effect. One key may drive several bits (e.g. two keys for P1 F1).
//  - Latency: key event -> buttons/start 2 cycles. Joystick -> buttons/start 1 cycle. All outputs registered.
//  - buttons = key bits | joystick bits. Spare bits are tied to 0.
//  - Coin source for slot c: keyboard coin key c OR joystick[c][7] (slot index = player index, clipped).
//    * A rising edge of the source loads the counter with COIN_PULSE. coin[c] = (counter != 0).
//    * While the counter runs, further edges are ignored: no retrigger and no extension.
//    * A held source produces exactly one pulse; the next pulse needs a release and a new press.
//    * Any two sources mapped to one slot are ORed before edge detection.
//  - Keymap: P1 R/L/D/U=E074/E06B/E072/E075, F1=29 or 14, F2=11.
//    P2 R/L/D/U=23/1C/1B/1D, F1=15, F2=0D.
//    start1=16 or 05, start2=1E or 06; coin1=2E, coin2=36.
//    Entries for players or coins >= the parameters are dropped.
//  - Mid-operation reset clears everything within one cycle. A key held across reset reads 0 until its next make event.
// CONFIGURATION
//  COIN_ON_START_EN defined:
//  - A start request (rising edge of key or joystick start for player p) runs a per-block FSM:
//    IDLE -> COIN (coin[0] pulsed COIN_PULSE cycles) -> GAP (START_DELAY cycles) -> START (start[p]=1 for COIN_PULSE cycles) -> IDLE.
//  - Requests outside IDLE are dropped.
//  - A normal coin pulse already running on slot 0 is not restarted; COIN waits for it to reach 0.
//  - Direct start passthrough is disabled.
//  COIN_ON_START_EN undefined: start = key start | joystick start, registered; no FSM is built.
// STRUCTURE
//  - Package arcade_input_pkg holds:
//    * BTN_* bit index constants
//    * key_entry_t typedef {code[7:0], ext, ext_care, kind, player, bit}
//    * KEYMAP constant array
//    * start FSM state enum
//  - Sub-module arcade_coin_pulse: one per slot, holds the edge detector and the COIN_PULSE down-counter.
//  - Instantiated with a generate loop.
// TESTING
//  1. Reset, then a 0x029 make with toggle flip -> buttons[4]=1 two cycles later; break -> 0 two cycles later.
//  2. 0x175 (extended up) make, then 0x075 make -> P1 buttons[3]=1 for both. 0x01D with ext=1 -> no change.
//  3. joystick[7] held 10000 cycles -> coin[0] high for exactly 2000 cycles, once. Release + press -> second pulse.
//  4. coin key pressed at cycle 500 of a running pulse -> pulse still ends at cycle 2000, no extension.
//  5. COIN_ON_START_EN: press P2 start -> coin[0] high 2000 cycles, low 4000, start[1] high 2000. Second press mid-FSM ignored.
//  6. Assert reset mid-pulse while key held -> all outputs 0 next cycle; no event on the first cycle after deassertion.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input front end: button bit indices,
// the PS/2 keymap table, and the coin-on-start FSM state type.
package arcade_input_pkg;

  localparam int unsigned BTN_R    = 0;
  localparam int unsigned BTN_L    = 1;
  localparam int unsigned BTN_D    = 2;
  localparam int unsigned BTN_U    = 3;
  localparam int unsigned BTN_F1   = 4;
  localparam int unsigned BTN_F2   = 5;
  localparam int unsigned KEY_BTNS = 6;

  typedef enum logic [1:0] {
    KIND_BTN,
    KIND_START,
    KIND_COIN
  } key_kind_t;

  // player holds the player index for buttons/start and the slot index for coins
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       ext_care;
    key_kind_t  kind;
    logic [1:0] player;
    logic [2:0] bit_idx;
  } key_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COIN,
    ST_GAP,
    ST_START
  } start_state_t;

  localparam int unsigned KEYMAP_LEN = 19;

  // Arrow keys (E0-prefixed) ignore the extended flag; everything else needs ext=0.
  localparam key_entry_t KEYMAP [KEYMAP_LEN] = '{
    '{8'h74, 1'b1, 1'b0, KIND_BTN,   2'd0, 3'(BTN_R)},
    '{8'h6B, 1'b1, 1'b0, KIND_BTN,   2'd0, 3'(BTN_L)},
    '{8'h72, 1'b1, 1'b0, KIND_BTN,   2'd0, 3'(BTN_D)},
    '{8'h75, 1'b1, 1'b0, KIND_BTN,   2'd0, 3'(BTN_U)},
    '{8'h29, 1'b0, 1'b1, KIND_BTN,   2'd0, 3'(BTN_F1)},
    '{8'h14, 1'b0, 1'b1, KIND_BTN,   2'd0, 3'(BTN_F1)},
    '{8'h11, 1'b0, 1'b1, KIND_BTN,   2'd0, 3'(BTN_F2)},
    '{8'h23, 1'b0, 1'b1, KIND_BTN,   2'd1, 3'(BTN_R)},
    '{8'h1C, 1'b0, 1'b1, KIND_BTN,   2'd1, 3'(BTN_L)},
    '{8'h1B, 1'b0, 1'b1, KIND_BTN,   2'd1, 3'(BTN_D)},
    '{8'h1D, 1'b0, 1'b1, KIND_BTN,   2'd1, 3'(BTN_U)},
    '{8'h15, 1'b0, 1'b1, KIND_BTN,   2'd1, 3'(BTN_F1)},
    '{8'h0D, 1'b0, 1'b1, KIND_BTN,   2'd1, 3'(BTN_F2)},
    '{8'h16, 1'b0, 1'b1, KIND_START, 2'd0, 3'd0},
    '{8'h05, 1'b0, 1'b1, KIND_START, 2'd0, 3'd0},
    '{8'h1E, 1'b0, 1'b1, KIND_START, 2'd1, 3'd0},
    '{8'h06, 1'b0, 1'b1, KIND_START, 2'd1, 3'd0},
    '{8'h2E, 1'b0, 1'b1, KIND_COIN,  2'd0, 3'd0},
    '{8'h36, 1'b0, 1'b1, KIND_COIN,  2'd1, 3'd0}
  };

  function automatic logic key_match(input key_entry_t e, input logic [8:0] key);
    return (e.code == key[7:0]) && (!e.ext_care || (e.ext == key[8]));
  endfunction

endpackage

// File: rtl/arcade_coin_pulse.sv
// One coin slot: rising-edge detect on the coin source and a fixed-length,
// non-retriggerable output pulse of COIN_PULSE cycles.
module arcade_coin_pulse #(
  parameter logic [15:0] COIN_PULSE = 16'd2000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic src,
  output logic pulse
);

  logic        src_q;
  logic [15:0] cnt;

  // Edge detect and down-counter; edges are ignored while the counter runs.
  // src_q tracks the source during reset so a source held through reset
  // does not produce a pulse on release of reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      src_q <= src;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      src_q <= src;
      if (src && !src_q && (cnt == '0)) begin
        cnt   <= COIN_PULSE;
        pulse <= 1'b1;
      end else if (cnt != '0) begin
        cnt   <= cnt - 16'd1;
        pulse <= (cnt != 16'd1);
      end
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Multi-player PS/2 + joystick input front end for arcade cores.
// Optional feature macro: COIN_ON_START_EN (start request inserts a coin,
// waits, then pulses start; direct start passthrough is disabled).
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned BTN_W       = 8,
  parameter int unsigned NUM_COINS   = 2,
  parameter logic [15:0] COIN_PULSE  = 16'd2000,
  parameter logic [15:0] START_DELAY = 16'd4000
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [10:0]                   ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]     joystick,
  output logic [BTN_W*NUM_PLAYERS-1:0]  buttons,
  output logic [NUM_PLAYERS-1:0]        start,
  output logic [NUM_COINS-1:0]          coin
);

  logic                                 toggle_q;
  logic                                 key_event;
  logic [NUM_PLAYERS-1:0][KEY_BTNS-1:0] key_btn;
  logic [NUM_PLAYERS-1:0]               key_start;
  logic [NUM_COINS-1:0]                 key_coin;
  logic [NUM_PLAYERS-1:0]               joy_start;
  logic [BTN_W*NUM_PLAYERS-1:0]         buttons_next;
  logic [NUM_COINS-1:0]                 coin_src;
  logic [NUM_COINS-1:0]                 slot_pulse;
  logic                                 joy_unused;

  // A PS/2 event is signalled by a flip of the toggle bit.
  always_comb key_event = ps2_key[10] ^ toggle_q;

  // Held key state: every matching keymap entry takes the make/break flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      toggle_q  <= ps2_key[10];
      key_btn   <= '0;
      key_start <= '0;
      key_coin  <= '0;
    end else begin
      toggle_q <= ps2_key[10];
      if (key_event) begin
        for (int unsigned i = 0; i < KEYMAP_LEN; i++) begin
          if (key_match(KEYMAP[i], ps2_key[8:0])) begin
            case (KEYMAP[i].kind)
              KIND_BTN:
                for (int unsigned p = 0; p < NUM_PLAYERS; p++)
                  if (KEYMAP[i].player == 2'(p)) key_btn[p][KEYMAP[i].bit_idx] <= ps2_key[9];
              KIND_START:
                for (int unsigned p = 0; p < NUM_PLAYERS; p++)
                  if (KEYMAP[i].player == 2'(p)) key_start[p] <= ps2_key[9];
              KIND_COIN:
                for (int unsigned c = 0; c < NUM_COINS; c++)
                  if (KEYMAP[i].player == 2'(c)) key_coin[c] <= ps2_key[9];
              default: ;
            endcase
          end
        end
      end
    end
  end

  // Merge key state with joystick bits; spare button bits stay 0.
  always_comb begin
    buttons_next = '0;
    joy_start    = '0;
    joy_unused   = 1'b0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      buttons_next[BTN_W*p +: KEY_BTNS] = key_btn[p] | joystick[16*p +: KEY_BTNS];
      joy_start[p] = joystick[16*p+6];
      joy_unused   = joy_unused ^ (^joystick[16*p+7 +: 9]);
    end
  end

  // Registered button outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) buttons <= '0;
    else       buttons <= buttons_next;
  end

  for (genvar c = 0; c < NUM_COINS; c++) begin : g_coin
    if (c < NUM_PLAYERS) begin : g_joy
      assign coin_src[c] = key_coin[c] | joystick[16*c+7];
    end else begin : g_key
      assign coin_src[c] = key_coin[c];
    end

    arcade_coin_pulse #(.COIN_PULSE(COIN_PULSE)) u_pulse (
      .clk_sys (clk_sys),
      .reset   (reset),
      .src     (coin_src[c]),
      .pulse   (slot_pulse[c])
    );
  end

`ifdef COIN_ON_START_EN
  start_state_t           state;
  logic [15:0]            fsm_cnt;
  logic                   fsm_coin;
  logic [1:0]             fsm_player;
  logic [NUM_PLAYERS-1:0] start_src_q;
  logic [NUM_PLAYERS-1:0] start_req;

  always_comb start_req = (key_start | joy_start) & ~start_src_q;

  // Coin-on-start sequencer; in COIN it first waits for any running slot-0
  // pulse to finish, then drives its own pulse (fsm_coin) for COIN_PULSE cycles.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= ST_IDLE;
      fsm_cnt     <= '0;
      fsm_coin    <= 1'b0;
      fsm_player  <= '0;
      start       <= '0;
      start_src_q <= key_start | joy_start;
    end else begin
      start_src_q <= key_start | joy_start;
      case (state)
        ST_IDLE: begin
          // descending scan so the lowest player index wins
          for (int unsigned p = NUM_PLAYERS; p > 0; p--) begin
            if (start_req[p-1]) begin
              fsm_player <= 2'(p - 1);
              state      <= ST_COIN;
            end
          end
        end
        ST_COIN: begin
          if (!fsm_coin) begin
            if (!slot_pulse[0]) begin
              fsm_coin <= 1'b1;
              fsm_cnt  <= COIN_PULSE - 16'd1;
            end
          end else if (fsm_cnt == '0) begin
            fsm_coin <= 1'b0;
            fsm_cnt  <= START_DELAY - 16'd1;
            state    <= ST_GAP;
          end else begin
            fsm_cnt <= fsm_cnt - 16'd1;
          end
        end
        ST_GAP: begin
          if (fsm_cnt == '0) begin
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) start[p] <= (fsm_player == 2'(p));
            fsm_cnt <= COIN_PULSE - 16'd1;
            state   <= ST_START;
          end else begin
            fsm_cnt <= fsm_cnt - 16'd1;
          end
        end
        ST_START: begin
          if (fsm_cnt == '0) begin
            start <= '0;
            state <= ST_IDLE;
          end else begin
            fsm_cnt <= fsm_cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Slot 0 carries both the normal coin pulse and the sequencer's pulse.
  always_comb begin
    coin    = slot_pulse;
    coin[0] = slot_pulse[0] | fsm_coin;
  end
`else
  localparam logic [15:0] unused_start_delay = START_DELAY;

  // Direct registered start passthrough.
  always_ff @(posedge clk_sys) begin
    if (reset) start <= '0;
    else       start <= key_start | joy_start;
  end

  always_comb coin = slot_pulse;
`endif

endmodule
